// File: rtl/mem_sram_pkg.sv
// Shared types and constants for the SRAM responder: FSM states, latency bounds, counter width.
package mem_sram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 8;

  // The counter is loaded with LATENCY-2, so it only needs to reach LAT_MAX-2.
  localparam int CNT_W = $clog2(LAT_MAX - 1);

endpackage

// File: rtl/mem_sram_array.sv
// Single-port word array with per-byte write enable; a read updates rdata on the next edge.
// rdata holds its value until the next read, so it doubles as the response data register.
module mem_sram_array
  import mem_sram_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             en,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) begin
            mem[idx][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/mem_sram_responder.sv
// SRAM slave with one outstanding transaction; response valid LATENCY cycles after grant.
// gnt is only offered in IDLE, so a master holding req until valid is accepted once.
module mem_sram_responder
  import mem_sram_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    LATENCY    = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    s_mem_req,
  output logic                    s_mem_gnt,
  input  logic [ADDR_WIDTH-1:0]   s_mem_addr,
  input  logic                    s_mem_we,
  input  logic [DATA_WIDTH/8-1:0] s_mem_be,
  input  logic [DATA_WIDTH-1:0]   s_mem_wdata,
  output logic                    s_mem_valid,
  output logic [DATA_WIDTH-1:0]   s_mem_rdata,
  output logic                    s_mem_error
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("mem_sram_responder: DATA_WIDTH must be 32");
  end
  if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
    $error("mem_sram_responder: LATENCY must be within 1..8");
  end
  if (MEM_DEPTH < 2 || (MEM_DEPTH & (MEM_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mem_sram_responder: MEM_DEPTH must be a power of 2");
  end
  if (ADDR_WIDTH < IDX_W + 3) begin : g_bad_addr_width
    $error("mem_sram_responder: ADDR_WIDTH too small for MEM_DEPTH");
  end
  if (BASE_ADDR[IDX_W+1:0] != '0) begin : g_bad_base
    $error("mem_sram_responder: BASE_ADDR must be aligned to MEM_DEPTH*4");
  end

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               resp_err;
  logic               resp_rd;
  logic               accept;
  logic               dec_err;
  logic [IDX_W-1:0]   idx;
  logic [31:0]        arr_rdata;

  // BASE_ADDR is aligned to the window size, so range check reduces to comparing upper bits.
  assign dec_err = (s_mem_addr[ADDR_WIDTH-1:IDX_W+2] != BASE_ADDR[ADDR_WIDTH-1:IDX_W+2]) ||
                   (s_mem_addr[1:0] != 2'b00);
  assign idx     = s_mem_addr[IDX_W+1:2];

  assign s_mem_gnt = s_mem_req && (state == IDLE) && rst_ni;
  assign accept    = s_mem_gnt;

  mem_sram_array #(
    .DEPTH (MEM_DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk_i (clk_i),
    .en    (accept && !dec_err),
    .we    (s_mem_we),
    .be    (s_mem_be),
    .idx   (idx),
    .wdata (s_mem_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      cnt      <= '0;
      resp_err <= 1'b0;
      resp_rd  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            resp_err <= dec_err;
            resp_rd  <= !s_mem_we;
            cnt      <= (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;
            state    <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign s_mem_valid = (state == RESP);
  assign s_mem_error = (state == RESP) && resp_err;
  assign s_mem_rdata = ((state == RESP) && resp_rd && !resp_err) ? arr_rdata : '0;

endmodule

// File: tb/tb_mem_sram_responder.sv
// Scoreboard bench: port 0 runs a LATENCY=1 responder, port 1 a LATENCY=3 responder.
module tb_mem_sram_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [3:0]  be    [2];
  logic [31:0] wdata [2];
  logic        gnt   [2];
  logic        valid [2];
  logic        err   [2];
  logic [31:0] rdata [2];

  int cyc = 0;
  int compared = 0;
  int mismatched = 0;
  int gcnt [2] = '{0, 0};
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_sram_responder #(
    .DATA_WIDTH (32), .ADDR_WIDTH (32), .MEM_DEPTH (1024), .BASE_ADDR (32'h0), .LATENCY (1)
  ) u_dut_l1 (
    .clk_i (clk), .rst_ni (rst_n),
    .s_mem_req (req[0]), .s_mem_gnt (gnt[0]), .s_mem_addr (addr[0]), .s_mem_we (we[0]),
    .s_mem_be (be[0]), .s_mem_wdata (wdata[0]), .s_mem_valid (valid[0]),
    .s_mem_rdata (rdata[0]), .s_mem_error (err[0])
  );

  mem_sram_responder #(
    .DATA_WIDTH (32), .ADDR_WIDTH (32), .MEM_DEPTH (1024), .BASE_ADDR (32'h0), .LATENCY (3)
  ) u_dut_l3 (
    .clk_i (clk), .rst_ni (rst_n),
    .s_mem_req (req[1]), .s_mem_gnt (gnt[1]), .s_mem_addr (addr[1]), .s_mem_we (we[1]),
    .s_mem_be (be[1]), .s_mem_wdata (wdata[1]), .s_mem_valid (valid[1]),
    .s_mem_rdata (rdata[1]), .s_mem_error (err[1])
  );

  function automatic int lat(input int p);
    return (p == 0) ? 1 : 3;
  endfunction

  function automatic int qsize(input int p);
    return (p == 0) ? q0.size() : q1.size();
  endfunction

  task automatic chk(input string name, input int p, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s port%0d @cycle %0d: got %h, want %h", name, p, cyc, act, exp);
    end
  endtask

  // Monitor: every response popped against the scoreboard; outputs must be 0 when not valid.
  always @(negedge clk) begin
    exp_t e;
    for (int p = 0; p < 2; p++) begin
      if (gnt[p]) gcnt[p]++;
      if (valid[p]) begin
        if (qsize(p) == 0) begin
          chk("valid_without_request", p, 32'(valid[p]), 32'h0);
        end else begin
          if (p == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk("rdata", p, rdata[p], e.rdata);
          chk("error", p, 32'(err[p]), 32'(e.err));
          chk("valid_cycle", p, cyc, e.cyc);
        end
      end else begin
        chk("idle_rdata", p, rdata[p], 32'h0);
        chk("idle_error", p, 32'(err[p]), 32'h0);
      end
    end
  end

  task automatic txn(input int p, input bit hold, input bit expect_resp, input logic w,
                     input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                     input logic [31:0] er, input logic ee);
    int   t;
    int   g0;
    exp_t e;
    g0 = gcnt[p];
    @(posedge clk); #1;
    req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d; be[p] = b;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!gnt[p] && t < 50);
    if (!gnt[p]) begin
      chk("gnt_timeout", p, 32'(gnt[p]), 32'h1);
      req[p] = 1'b0;
      return;
    end
    e.rdata = er;
    e.err   = ee;
    e.cyc   = cyc + lat(p);
    if (expect_resp) begin
      if (p == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    @(posedge clk); #1;
    // Junk on the bus after acceptance must not affect the response.
    addr[p]  = 32'h0000_0002;
    wdata[p] = 32'h5A5A_0F0F;
    if (!hold) req[p] = 1'b0;
    if (!expect_resp) return;
    t = 0;
    while (qsize(p) != 0 && t < 20) begin
      @(negedge clk); #1;
      t++;
    end
    if (qsize(p) != 0) begin
      chk("resp_timeout", p, qsize(p), 32'h0);
      if (p == 0) q0.delete();
      else        q1.delete();
    end
    req[p] = 1'b0;
    @(posedge clk); #1;
    chk("gnt_count", p, gcnt[p] - g0, 32'h1);
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0; we[p] = 1'b0; addr[p] = 32'h0; wdata[p] = 32'h0; be[p] = 4'h0;
    end
    #1 rst_n = 1'b0;
    req[0] = 1'b1; req[1] = 1'b1; addr[0] = 32'h100; addr[1] = 32'h100;
    repeat (3) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        chk("rst_gnt", p, 32'(gnt[p]), 32'h0);
        chk("rst_valid", p, 32'(valid[p]), 32'h0);
        chk("rst_rdata", p, rdata[p], 32'h0);
        chk("rst_error", p, 32'(err[p]), 32'h0);
      end
    end
    @(posedge clk); #1;
    req[0] = 1'b0; req[1] = 1'b0; rst_n = 1'b1;

    // LATENCY=1 port
    txn(0, 0, 1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0);
    txn(0, 0, 1, 1'b0, 32'h100, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0);
    txn(0, 0, 1, 1'b1, 32'h0,   32'hA5A5_5A5A, 4'hF, 32'h0,         1'b0);
    txn(0, 0, 1, 1'b0, 32'h1000, 32'h0,        4'h0, 32'h0,         1'b1);
    txn(0, 0, 1, 1'b0, 32'h2,   32'h0,         4'h0, 32'h0,         1'b1);
    txn(0, 0, 1, 1'b1, 32'h1000, 32'h1234_5678, 4'hF, 32'h0,        1'b1);
    txn(0, 0, 1, 1'b1, 32'h2,   32'h8765_4321, 4'hF, 32'h0,         1'b1);
    txn(0, 0, 1, 1'b0, 32'h0,   32'h0,         4'h0, 32'hA5A5_5A5A, 1'b0);
    txn(0, 0, 1, 1'b1, 32'hFFC, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b0);
    txn(0, 0, 1, 1'b0, 32'hFFC, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0);
    txn(0, 0, 1, 1'b1, 32'h100, 32'h0,         4'h0, 32'h0,         1'b0);
    txn(0, 1, 1, 1'b0, 32'h100, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0);

    // LATENCY=3 port
    txn(1, 0, 1, 1'b1, 32'h8,   32'hFFFF_FFFF, 4'hF, 32'h0,         1'b0);
    txn(1, 0, 1, 1'b1, 32'h8,   32'h1122_3344, 4'h5, 32'h0,         1'b0);
    txn(1, 0, 1, 1'b0, 32'h8,   32'h0,         4'h0, 32'hFF22_FF44, 1'b0);
    txn(1, 1, 1, 1'b1, 32'hC,   32'h0BAD_F00D, 4'hF, 32'h0,         1'b0);
    txn(1, 1, 1, 1'b0, 32'hC,   32'h0,         4'h0, 32'h0BAD_F00D, 1'b0);
    txn(1, 0, 1, 1'b0, 32'h1004, 32'h0,        4'h0, 32'h0,         1'b1);

    // Reset while the LATENCY=3 responder sits in WAIT: the read must never respond.
    txn(1, 1, 0, 1'b0, 32'h8,   32'h0,         4'h0, 32'h0,         1'b0);
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("midrst_gnt", 1, 32'(gnt[1]), 32'h0);
      chk("midrst_valid", 1, 32'(valid[1]), 32'h0);
      chk("midrst_rdata", 1, rdata[1], 32'h0);
      chk("midrst_error", 1, 32'(err[1]), 32'h0);
    end
    @(posedge clk); #1;
    req[1] = 1'b0; rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    txn(1, 0, 1, 1'b0, 32'h8,   32'h0,         4'h0, 32'hFF22_FF44, 1'b0);
    txn(0, 0, 1, 1'b0, 32'h100, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_sram_responder.md
MEM_SRAM_RESPONDER -- requirements
Module: mem_sram_responder

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the data bus width; only 32 is supported.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, giving the address bus width.
REQ-003 The block SHALL have parameter MEM_DEPTH, default 1024, giving the number of words; it SHALL be a power of 2.
REQ-004 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, giving the byte address of word 0; it SHALL be aligned to MEM_DEPTH*4.
REQ-005 The block SHALL have parameter LATENCY, default 1, giving the accept-to-response delay in cycles; the legal range is 1..8.
REQ-006 clk_i  in  1  clock; one clock domain, all logic on the rising edge.
REQ-007 rst_ni  in  1  reset, asynchronous, active-low.
REQ-008 s_mem_req  in  1  request from the master.
REQ-009 s_mem_gnt  out  1  request accepted.
REQ-010 s_mem_addr  in  ADDR_WIDTH  byte address.
REQ-011 s_mem_we  in  1  1 = write, 0 = read.
REQ-012 s_mem_be  in  DATA_WIDTH/8  byte enables for writes.
REQ-013 s_mem_wdata  in  DATA_WIDTH  write data.
REQ-014 s_mem_valid  out  1  response valid, single-cycle pulse.
REQ-015 s_mem_rdata  out  DATA_WIDTH  read data; qualified by s_mem_valid.
REQ-016 s_mem_error  out  1  response error; qualified by s_mem_valid.

Function
REQ-017 The control FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-018 s_mem_gnt SHALL be combinational and SHALL equal s_mem_req AND (state==IDLE) AND rst_ni.
- Only one transaction is outstanding at a time.
- A master that holds req until valid (PicoRV32 style) is therefore never accepted twice.
REQ-019 A request is accepted in cycle N when req and gnt are both high in that cycle.
REQ-020 On acceptance the next state SHALL be RESP if LATENCY==1, and WAIT otherwise.
- The latency counter SHALL load LATENCY-2 on acceptance.
REQ-021 In WAIT the counter SHALL decrement each cycle; the FSM SHALL move to RESP on the cycle the counter is 0.
REQ-022 In RESP, s_mem_valid SHALL be 1 for exactly one cycle (cycle N+LATENCY), and the next state SHALL be IDLE.
REQ-023 A new request SHALL be acceptable no earlier than cycle N+LATENCY+1.
REQ-024 The address decode SHALL flag an error when addr is outside [BASE_ADDR, BASE_ADDR+MEM_DEPTH*4) or when addr[1:0] != 0.
REQ-025 The word index SHALL be addr[log2(MEM_DEPTH)+1:2].
REQ-026 An accepted write without error SHALL update only the bytes whose be bit is 1, in the acceptance cycle.
- be==0 is a legal no-op and SHALL still produce a response.
REQ-027 An accepted read without error SHALL sample array data at acceptance and hold it in a response register until RESP.
- A read issued after a write to the same word SHALL return the written data.
REQ-028 For every error response, s_mem_error SHALL be 1, no array write SHALL occur, and s_mem_rdata SHALL be 0.
REQ-029 For every write response, s_mem_rdata SHALL be 0.
REQ-030 s_mem_rdata and s_mem_error SHALL be 0 whenever s_mem_valid is 0.
REQ-031 Changes on req, addr or wdata while in WAIT or RESP SHALL be ignored.

Reset
REQ-032 While rst_ni is low, the state SHALL be IDLE, the counter 0, and s_mem_gnt, s_mem_valid, s_mem_rdata and s_mem_error SHALL all be 0.
REQ-033 Reset asserted mid-transaction SHALL abort the transaction with no response.
- A write already accepted remains committed.
REQ-034 Memory contents SHALL NOT be reset.

Structure
REQ-035 Package mem_sram_pkg SHALL hold:
- the FSM state enum (IDLE/WAIT/RESP);
- the LATENCY bounds constants;
- the counter width constant.
REQ-036 The storage SHALL be a single sub-module, mem_sram_array: single-port, synchronous read, per-byte write enable, depth MEM_DEPTH.
REQ-037 An elaboration-time check SHALL reject illegal values of LATENCY, MEM_DEPTH or BASE_ADDR.

Verification
REQ-038 LATENCY=1: write 0x100 data 0xDEADBEEF be=0xF, then read 0x100 -> each valid one cycle after gnt, rdata=0xDEADBEEF, error=0.
REQ-039 LATENCY=3: write be=0x5 data 0x11223344 over 0xFFFFFFFF at 0x8, then read 0x8 -> valid 3 cycles after gnt, rdata=0xFF22FF44.
REQ-040 Read 0x1000 (out of range, MEM_DEPTH=1024) and read 0x2 (misaligned) -> error=1, rdata=0; the contents at 0x0 are unchanged.
REQ-041 req held high through the response -> exactly one gnt and one valid per transaction; gnt stays low in WAIT/RESP.
REQ-042 rst_ni pulsed low during WAIT -> valid is never asserted, outputs are 0 during reset, and the next request completes normally.
